// File: rtl/spike_event_arbiter.sv
// Round-robin serialiser for single-cycle neuron spikes onto a valid/ready event bus.
// Spikes that arrive while their source still has an unserved event are counted as drops.
module spike_event_arbiter #(
    parameter int N_SOURCES    = 8,
    parameter int ID_WIDTH     = 3,
    parameter int CNT_WIDTH    = 8,
    parameter int NEURON_LEVEL = -1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SOURCES-1:0] spike_in,
    output logic                 ev_valid,
    output logic [ID_WIDTH-1:0]  ev_id,
    input  logic                 ev_ready,
    output logic                 busy,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int PW = $clog2(N_SOURCES + 1);
    localparam int SW = CNT_WIDTH + PW;
    localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_WIDTH{1'b1}}};

    // NEURON_LEVEL only tags the instance; -1 means "unassigned".
    if (N_SOURCES < 2 || (2 ** ID_WIDTH) < N_SOURCES || NEURON_LEVEL < -1) begin : g_param_check
        $error("spike_event_arbiter: illegal parameter set");
    end

    function automatic logic [PW-1:0] count_ones(input logic [N_SOURCES-1:0] v);
        logic [PW-1:0] c;
        c = {PW{1'b0}};
        for (int i = 0; i < N_SOURCES; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    logic [N_SOURCES-1:0] pending_r;
    logic [ID_WIDTH-1:0]  rr_ptr_r;

    logic                 load_s;
    logic                 found_s;
    logic                 grant_s;
    logic [ID_WIDTH-1:0]  winner_s;
    logic [ID_WIDTH:0]    cand_s;
    logic [N_SOURCES-1:0] grant_mask_s;
    logic [N_SOURCES-1:0] drop_vec_s;
    logic [N_SOURCES-1:0] pending_nxt_s;
    logic [PW-1:0]        drop_num_s;
    logic [SW-1:0]        cnt_sum_s;
    logic [CNT_WIDTH-1:0] drop_cnt_nxt_s;

    assign load_s = !ev_valid || ev_ready;
    assign busy   = (|pending_r) || ev_valid;

    // Round-robin scan starting one past the last granted source, wrapping at N_SOURCES.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {ID_WIDTH{1'b0}};
        cand_s   = {(ID_WIDTH + 1){1'b0}};
        for (int k = 1; k <= N_SOURCES; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_WIDTH + 1)'(k);
            cand_s = (cand_s >= (ID_WIDTH + 1)'(N_SOURCES)) ? cand_s - (ID_WIDTH + 1)'(N_SOURCES) : cand_s;
            if (!found_s && pending_r[cand_s[ID_WIDTH-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[ID_WIDTH-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant mask, pending update and drop detection; a re-spike on the granted source is a new event.
    always_comb begin
        grant_s      = load_s && found_s;
        grant_mask_s = {N_SOURCES{1'b0}};
        if (grant_s) begin
            grant_mask_s[winner_s] = 1'b1;
        end else begin
            grant_mask_s = {N_SOURCES{1'b0}};
        end
        drop_vec_s    = spike_in & pending_r & ~grant_mask_s;
        pending_nxt_s = (pending_r & ~grant_mask_s) | spike_in;
    end

    // Saturating drop counter next value.
    always_comb begin
        drop_num_s = count_ones(drop_vec_s);
        cnt_sum_s  = SW'(drop_count) + SW'(drop_num_s);
        if (cnt_sum_s > CNT_MAX) begin
            drop_cnt_nxt_s = {CNT_WIDTH{1'b1}};
        end else begin
            drop_cnt_nxt_s = cnt_sum_s[CNT_WIDTH-1:0];
        end
    end

    // State and registered outputs; the token holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= {N_SOURCES{1'b0}};
            rr_ptr_r   <= ID_WIDTH'(N_SOURCES - 1);
            ev_valid   <= 1'b0;
            ev_id      <= {ID_WIDTH{1'b0}};
            drop_pulse <= 1'b0;
            drop_count <= {CNT_WIDTH{1'b0}};
        end else begin
            pending_r  <= pending_nxt_s;
            drop_pulse <= |drop_vec_s;
            drop_count <= drop_cnt_nxt_s;
            if (grant_s) begin
                ev_valid <= 1'b1;
                ev_id    <= winner_s;
                rr_ptr_r <= winner_s;
            end else if (load_s) begin
                ev_valid <= 1'b0;
            end else begin
                ev_valid <= ev_valid;
            end
        end
    end

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with a 2-bit drop counter shares all inputs to exercise saturation.
module tb_spike_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] spike_in = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid, busy, drop_pulse;
    logic [2:0] ev_id;
    logic [7:0] drop_count;
    logic       ev_valid2, busy2, drop_pulse2;
    logic [2:0] ev_id2;
    logic [1:0] drop_count2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pend [8];
    bit m_valid;
    bit m_pulse;
    int m_id;
    int m_last;
    int m_drops;

    spike_event_arbiter #(.N_SOURCES(8), .ID_WIDTH(3), .CNT_WIDTH(8), .NEURON_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .ev_valid(ev_valid), .ev_id(ev_id),
        .ev_ready(ev_ready), .busy(busy), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    spike_event_arbiter #(.N_SOURCES(8), .ID_WIDTH(3), .CNT_WIDTH(2), .NEURON_LEVEL(1)) dut2 (
        .clk(clk), .rst(rst), .spike_in(spike_in), .ev_valid(ev_valid2), .ev_id(ev_id2),
        .ev_ready(ev_ready), .busy(busy2), .drop_pulse(drop_pulse2), .drop_count(drop_count2)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int i = 0; i < 8; i++) b = b | m_pend[i];
        return b;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Apply one edge of the arbitration rules to the model.
    task automatic model_update(input logic [7:0] sp, input logic rdy, input logic r);
        int g, nd, j;
        bit load;
        if (r) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0; m_pulse = 1'b0; m_id = 0; m_last = 7; m_drops = 0;
            return;
        end
        load = !m_valid || rdy;
        g = -1;
        if (load) begin
            for (int k = 1; k <= 8; k++) begin
                j = (m_last + k) % 8;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        nd = 0;
        for (int i = 0; i < 8; i++) if (sp[i] && m_pend[i] && i != g) nd++;
        for (int i = 0; i < 8; i++) m_pend[i] = (i == g) ? sp[i] : (m_pend[i] | sp[i]);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1; m_id = g; m_last = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_drops += nd;
        m_pulse = (nd > 0);
    endtask

    task automatic step(input logic [7:0] sp, input logic rdy, input logic r);
        spike_in = sp; ev_ready = rdy; rst = r;
        @(posedge clk);
        model_update(sp, rdy, r);
        #1;
    endtask

    task automatic test_reset();
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ev_valid); end
        checks++; if (ev_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", ev_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (drop_pulse !== 1'b0 || drop_count !== 8'd0 || drop_count2 !== 2'd0) begin
            errors++; $display("FAIL reset_drop got %0b/%0d/%0d want 0/0/0", drop_pulse, drop_count, drop_count2);
        end
    endtask

    task automatic test_single();
        step(8'h00, 1'b1, 1'b1);
        step(8'b0000_0100, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_lat1 got v=%0b busy=%0b want v=0 busy=1", ev_valid, busy);
        end
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 3'd2) begin
            errors++; $display("FAIL single_tok got v=%0b id=%0d want v=1 id=2", ev_valid, ev_id);
        end
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL single_after got v=%0b busy=%0b cnt=%0d want 0 0 0", ev_valid, busy, drop_count);
        end
    endtask

    task automatic test_all_sources();
        step(8'h00, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 1'b1, 1'b0);
            checks++; if (ev_valid !== 1'b1 || ev_id !== 3'(k)) begin
                errors++; $display("FAIL all_seq[%0d] got v=%0b id=%0d want v=1 id=%0d", k, ev_valid, ev_id, k);
            end
        end
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL all_end got v=%0b busy=%0b want 0 0", ev_valid, busy);
        end
    endtask

    task automatic test_fairness();
        step(8'h00, 1'b1, 1'b1);
        step(8'h21, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(8'h21, 1'b1, 1'b0);
            checks++; if (ev_valid !== 1'b1 || ev_id !== ((k % 2 == 0) ? 3'd0 : 3'd5)) begin
                errors++; $display("FAIL fair_seq[%0d] got v=%0b id=%0d want v=1 id=%0d", k, ev_valid, ev_id, (k % 2 == 0) ? 0 : 5);
            end
        end
        checks++; if (drop_count !== 8'd12 || drop_count2 !== 2'd3) begin
            errors++; $display("FAIL fair_drops got %0d/%0d want 12/3", drop_count, drop_count2);
        end
    endtask

    task automatic test_backpressure();
        step(8'h00, 1'b0, 1'b1);
        step(8'b0000_0011, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step((k == 2) ? 8'b0000_0010 : 8'h00, 1'b0, 1'b0);
            checks++; if (ev_valid !== 1'b1 || ev_id !== 3'd0 || drop_pulse !== (k == 2)) begin
                errors++; $display("FAIL bp_stall[%0d] got v=%0b id=%0d pulse=%0b want v=1 id=0 pulse=%0b",
                                   k, ev_valid, ev_id, drop_pulse, (k == 2));
            end
        end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL bp_count got %0d want 1", drop_count); end
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 3'd1) begin
            errors++; $display("FAIL bp_release got v=%0b id=%0d want v=1 id=1", ev_valid, ev_id);
        end
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", ev_valid); end
    endtask

    task automatic test_saturation();
        int exp2;
        step(8'h00, 1'b0, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            step(8'h01, 1'b0, 1'b0);
            exp2 = sat((j > 2) ? j - 2 : 0, 3);
            checks++; if (drop_count2 !== 2'(exp2)) begin
                errors++; $display("FAIL sat_cnt2[%0d] got %0d want %0d", j, drop_count2, exp2);
            end
        end
        checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got %0d want 5", drop_count); end
    endtask

    task automatic test_mid_reset();
        step(8'h00, 1'b0, 1'b1);
        step(8'hF0, 1'b0, 1'b0);
        step(8'hF0, 1'b0, 1'b0);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 3'd4 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre got v=%0b id=%0d busy=%0b want 1 4 1", ev_valid, ev_id, busy);
        end
        step(8'h00, 1'b0, 1'b1);
        checks++; if (ev_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_rst got v=%0b busy=%0b cnt=%0d want 0 0 0", ev_valid, busy, drop_count);
        end
        step(8'b0100_0000, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 3'd6) begin
            errors++; $display("FAIL mid_next got v=%0b id=%0d want 1 6", ev_valid, ev_id);
        end
    endtask

    task automatic test_random();
        logic [7:0] sp;
        step(8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            sp = 8'($urandom) & 8'($urandom);
            step(sp, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (ev_valid !== m_valid || (m_valid && ev_id !== 3'(m_id)) || busy !== m_busy() ||
                drop_pulse !== m_pulse || drop_count !== 8'(sat(m_drops, 255)) ||
                drop_count2 !== 2'(sat(m_drops, 3)) || ev_valid2 !== m_valid) begin
                errors++;
                $display("FAIL rand[%0d] got v=%0b id=%0d busy=%0b pulse=%0b cnt=%0d cnt2=%0d want v=%0b id=%0d busy=%0b pulse=%0b cnt=%0d cnt2=%0d",
                         n, ev_valid, ev_id, busy, drop_pulse, drop_count, drop_count2,
                         m_valid, m_id, m_busy(), m_pulse, sat(m_drops, 255), sat(m_drops, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
